// File: rtl/expr_arb_pkg.sv
// Shared types and helpers for the expr_arb two-port expression arbiter.
// Evaluation functions here describe stage-1 and stage-2 arithmetic once for the top.
package expr_arb_pkg;

    localparam int Y_W = 30;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    typedef struct packed {
        logic [3:0] a0;
        logic [5:0] a1;
        logic [3:0] b0;
        logic [5:0] b1;
    } operand_t;

    typedef struct packed {
        logic [Y_W-1:0] y;
        logic           tag;
    } result_t;

    // Left term: 6-bit inequality between ~a1 and the zero-extended (a1 < a0) flag.
    function automatic logic eval_l(input operand_t op);
        logic lt;
        lt = op.a1 < {2'b00, op.a0};
        return (~op.a1) != {5'b00000, lt};
    endfunction

    // Right term: a shift amount of 4 or more empties b0, so the compare sees 0.
    function automatic logic eval_r(input operand_t op);
        logic [3:0] sh;
        sh = op.b0 >> op.a1;
        return sh <= {3'b000, ^op.a1};
    endfunction

    function automatic logic [Y_W-1:0] make_y(input logic l, input logic r);
        logic [3:0] y0;
        y0 = {3'b000, l != r};
        return {6'b000000, {6{y0}}};
    endfunction

endpackage

// File: rtl/expr_arb_fifo.sv
// Synchronous result FIFO for expr_arb: DEPTH entries (power of two), count output,
// head word presented combinationally and forced to zero while empty.
module expr_arb_fifo #(
    parameter int  DEPTH = 2,
    parameter int  W     = 31,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          clr,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic [CW-1:0] count,
    output logic          not_empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        // A full FIFO still takes a push when the head leaves in the same cycle.
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    assign not_empty = (count_q != '0);
    assign count     = count_q;
    assign pop_data  = not_empty ? mem[rd_ptr_q] : '0;

endmodule

// File: rtl/expr_arb.sv
// Two-port round-robin arbiter sharing one two-stage expression evaluator, with result FIFO.
// Define EXPR_ARB_STATS_EN to add saturating per-port grant counters gnt_cnt0/gnt_cnt1.
module expr_arb
    import expr_arb_pkg::*;
#(
    parameter int OUT_DEPTH = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [1:0]       rq_valid,
    output logic [1:0]       rq_ready,
    input  logic [1:0][3:0]  rq_a0,
    input  logic [1:0][5:0]  rq_a1,
    input  logic [1:0][3:0]  rq_b0,
    input  logic [1:0][5:0]  rq_b1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Y_W-1:0]   out_y,
`ifdef EXPR_ARB_STATS_EN
    output logic             out_tag,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
`else
    output logic             out_tag
`endif
);

    localparam int CW  = $clog2(OUT_DEPTH) + 1;
    localparam int CW1 = CW + 1;

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_FLUSH = FLUSH;

    logic [1:0]    state_q, state_d;
    logic          ptr_q, ptr_d;
    logic          s1_valid_q, s1_valid_d;
    logic          s1_l_q, s1_l_d;
    logic          s1_r_q, s1_r_d;
    logic          s1_tag_q, s1_tag_d;

    operand_t      op [2];
    operand_t      sel_op;
    logic [1:0]    hs;
    logic          accept;
    logic          acc_port;
    logic          pop;
    logic          push;
    logic          space;
    logic          can_accept;
    logic          fifo_busy_next;
    logic [CW:0]   inflight;
    logic [CW-1:0] fifo_count;
    logic          fifo_not_empty;
    result_t       s2_res;
    result_t       fifo_out;
    logic          unused_b1;

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign op[gi] = {rq_a0[gi], rq_a1[gi], rq_b0[gi], rq_b1[gi]};
        // The pointer port always sees ready; the other port only while the pointer port is idle.
        assign rq_ready[gi] = can_accept && ((ptr_q == 1'(gi)) || !rq_valid[1-gi]);
    end

    assign pop        = fifo_not_empty && out_ready;
    assign inflight   = {1'b0, fifo_count} + {{CW{1'b0}}, s1_valid_q};
    assign space      = inflight < CW1'(OUT_DEPTH);
    assign can_accept = !reset && !flush && (state_q != ST_FLUSH) && (space || pop);

    assign hs        = rq_valid & rq_ready;
    assign accept    = |hs;
    assign acc_port  = hs[1];
    assign sel_op    = op[acc_port];
    assign unused_b1 = ^sel_op.b1;

    // Stage 1 always drains into the FIFO: the acceptance rule keeps stage 1 plus FIFO within OUT_DEPTH.
    assign push           = s1_valid_q && !flush;
    assign fifo_busy_next = s1_valid_q || (fifo_count > CW'(pop));

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        s1_valid_d = accept;
        s1_l_d     = s1_l_q;
        s1_r_d     = s1_r_q;
        s1_tag_d   = s1_tag_q;
        if (accept) begin
            s1_l_d   = eval_l(sel_op);
            s1_r_d   = eval_r(sel_op);
            s1_tag_d = acc_port;
            ptr_d    = ~acc_port;
        end
        if (flush) begin
            s1_valid_d = 1'b0;
            state_d    = ST_FLUSH;
        end else if (state_q == ST_FLUSH) begin
            state_d = ST_IDLE;
        end else begin
            state_d = (accept || fifo_busy_next) ? ST_RUN : ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_l_q     <= 1'b0;
            s1_r_q     <= 1'b0;
            s1_tag_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            s1_valid_q <= s1_valid_d;
            s1_l_q     <= s1_l_d;
            s1_r_q     <= s1_r_d;
            s1_tag_q   <= s1_tag_d;
        end
    end

    assign s2_res = '{y: make_y(s1_l_q, s1_r_q), tag: s1_tag_q};

    expr_arb_fifo #(
        .DEPTH (OUT_DEPTH),
        .W     ($bits(result_t))
    ) u_fifo (
        .clk       (clk),
        .srst      (reset),
        .clr       (flush),
        .push      (push),
        .push_data (s2_res),
        .pop       (pop),
        .pop_data  (fifo_out),
        .count     (fifo_count),
        .not_empty (fifo_not_empty)
    );

    assign out_valid = fifo_not_empty;
    assign out_y     = fifo_out.y;
    assign out_tag   = fifo_out.tag;

`ifdef EXPR_ARB_STATS_EN
    logic [CNT_W-1:0] gnt_cnt_q [2];
    logic [CNT_W-1:0] gnt_cnt_d [2];

    // Flush deliberately leaves these alone; only reset clears them.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            gnt_cnt_d[i] = gnt_cnt_q[i];
            if (hs[i] && !(&gnt_cnt_q[i])) begin
                gnt_cnt_d[i] = gnt_cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                gnt_cnt_q[i] <= '0;
            end else begin
                gnt_cnt_q[i] <= gnt_cnt_d[i];
            end
        end
    end

    assign gnt_cnt0 = gnt_cnt_q[0];
    assign gnt_cnt1 = gnt_cnt_q[1];
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: doc/expr_arb.md
EXPR_ARB -- requirements
Module: expr_arb

Interface
REQ-001 SHALL have parameter OUT_DEPTH, default 2: result FIFO depth (power of two, >=2).
REQ-002 SHALL have parameter CNT_W, default 16: width of the grant counters (see Configuration).
REQ-003 SHALL run on a single clock, clk, with synchronous, active-high reset, reset.
REQ-004 SHALL have ports, in this order:
- clk, input, 1: clock.
- reset, input, 1: sync active-high reset.
- flush, input, 1: discard in-flight work.
- rq_valid, input, 2: per-requester request valid.
- rq_ready, output, 2: per-requester accept.
- rq_a0, input, 2x4: operand a0 per port.
- rq_a1, input, 2x6: operand a1 per port.
- rq_b0, input, 2x4: operand b0 per port.
- rq_b1, input, 2x6: operand b1 per port; carried through, unused by evaluation.
- out_valid, output, 1: result valid.
- out_ready, input, 1: result accept.
- out_y, output, 30: result word.
- out_tag, output, 1: requester index.

Function
REQ-005 SHALL share one evaluator between two requesters; at most one request SHALL be accepted per cycle.
REQ-006 Arbitration SHALL be round-robin; the pointer SHALL move past the granted port only on an accepted handshake.
REQ-007 rq_ready[i] SHALL be high only for the granted port, and only when space = (fifo_count + s1_valid) < OUT_DEPTH, or out_valid&out_ready in the same cycle.
REQ-008 rq_ready SHALL not depend on rq_valid of the same port; it MAY depend on rq_valid of the other port.
REQ-009 Stage 1 (registered) SHALL compute:
- L = ({~a1} != {5'b0,(a1<a0)}), 6-bit unsigned compare.
- R = ((b0 >> a1) <= ^a1): 4-bit logical shift by the full 6-bit amount; shifts >=4 give 0; compare unsigned.
REQ-010 Stage 2 SHALL compute y0 = {3'b0, L != R} and write out_y = {6'b0, y0,y0,y0,y0,y0,y0} into the FIFO with its tag.
REQ-011 Latency: a request accepted at edge E SHALL appear on out_valid after edge E+1 if the FIFO was empty.
REQ-012 Results SHALL leave in acceptance order; out_y and out_tag SHALL be stable while out_valid & !out_ready.
REQ-013 FIFO full: no new accept; stage 1 SHALL never overwrite an unwritten result.
REQ-014 Simultaneous FIFO push and pop when full-minus-pop SHALL be legal, with no loss and no duplication.
REQ-015 The control FSM SHALL have states IDLE (no work in flight), RUN (s1_valid or FIFO non-empty) and FLUSH.
REQ-016 flush SHALL take effect at the next edge, from any state:
- stage 1 and the FIFO are cleared;
- the FSM enters FLUSH for exactly one cycle with rq_ready=0, then goes to IDLE;
- the arbitration pointer is kept.
REQ-017 Handshakes presented in the flush cycle SHALL be dropped; rq_ready SHALL be 0 in that cycle.

Reset
REQ-018 On reset, at the next edge:
- rq_ready=0, out_valid=0, out_y=0, out_tag=0;
- FSM=IDLE, pointer=port 0, FIFO empty, s1_valid=0;
- counters=0.
REQ-019 Reset SHALL override flush and any handshake in the same cycle, and SHALL abort any in-flight operation without emitting a result.

Configuration
REQ-020 With EXPR_ARB_STATS_EN defined, the block SHALL add outputs gnt_cnt0 and gnt_cnt1 (CNT_W each) after out_tag:
- each counts accepted requests per port;
- saturates at all-ones;
- is cleared by reset only, not by flush.
REQ-021 Without EXPR_ARB_STATS_EN, those ports and that logic SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-022 A shared package expr_arb_pkg SHALL hold:
- the FSM state enum (IDLE, RUN, FLUSH);
- the operand struct {a0,a1,b0,b1};
- the result struct {y,tag};
- the constant Y_W=30.
REQ-023 The result buffer SHALL be a sub-module expr_arb_fifo (synchronous FIFO, OUT_DEPTH entries, count output); the arbiter, evaluator and FSM SHALL stay in expr_arb.

Verification
REQ-024 Reset, then port 0 sends a0=0,a1=0,b0=0,b1=0 with out_ready=1 -> out_y=30'h0 and tag 0 two cycles after accept.
REQ-025 Port 1 sends a0=0,a1=6'h3F,b0=4'h5 -> out_y=30'h0111111, out_tag=1.
REQ-026 Both ports valid continuously, out_ready=1 -> grants alternate 0,1,0,1, with throughput 1 per cycle.
REQ-027 out_ready=0 with continuous requests -> exactly OUT_DEPTH accepts, then rq_ready=0; releasing out_ready drains in order with no loss.
REQ-028 flush with 1 result in stage 1 and 2 in the FIFO -> out_valid=0 next cycle, rq_ready=0 for one cycle, then IDLE; no stale result appears.
REQ-029 With EXPR_ARB_STATS_EN defined and CNT_W=4, 20 accepts on port 0 -> gnt_cnt0=4'hF, gnt_cnt1=0.
